// File: rtl/cmac_chk_pkg.sv
// cmac_chk_pkg: shared widths, FSM states and saturating helper for the CMAC RX checker.
package cmac_chk_pkg;
    localparam int AXIS_DW    = 512;
    localparam int KEEP_W     = 64;
    localparam int LEN_W      = 14;
    localparam int CNT_W      = 32;
    localparam int BYTE_CNT_W = 48;

    typedef enum logic [2:0] {IDLE, WAIT_SOP, IN_PKT, DROP, DONE} state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return &v ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/cmac_chk_beat_cmp.sv
// cmac_chk_beat_cmp: registered per-beat payload-pattern mismatch and tkeep legality.
// Only beat index mod 4 matters since the pattern byte is taken mod 256.
module cmac_chk_beat_cmp
    import cmac_chk_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [AXIS_DW-1:0] data_i,
    input  logic [KEEP_W-1:0]  keep_i,
    input  logic [1:0]         idx_i,
    input  logic [7:0]         seq8_i,
    input  logic               first_i,
    input  logic               last_i,
    output logic               mism_o,
    output logic               keep_ok_o
);
    logic [KEEP_W-1:0] bad;
    logic              keep_ok;
    logic              mism_q, keep_ok_q;

    genvar b;
    for (b = 0; b < KEEP_W; b++) begin : g_byte
        assign bad[b] = keep_i[b] && !(first_i && b < 4) &&
                        data_i[8*b +: 8] != 8'({idx_i, 6'(b)} + seq8_i);
    end

    assign keep_ok = last_i ? (|keep_i && (keep_i & (keep_i + 1'b1)) == '0) : &keep_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mism_q    <= 1'b0;
            keep_ok_q <= 1'b0;
        end else begin
            mism_q    <= |bad;
            keep_ok_q <= keep_ok;
        end
    end

    assign mism_o    = mism_q;
    assign keep_ok_o = keep_ok_q;
endmodule

// File: rtl/cmac_rx_pkt_checker.sv
// cmac_rx_pkt_checker: checks TX-generator frames on the CMAC RX AXI4-Stream.
// Define CMAC_RX_CHK_BYTE_CNT_EN to enable the 48-bit byte counter.
module cmac_rx_pkt_checker
    import cmac_chk_pkg::*;
#(
    parameter int NUM_PKTS = 1000,
    parameter int MIN_LEN  = 64,
    parameter int MAX_LEN  = 9600
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_restart,
    input  logic [AXIS_DW-1:0]    rx_tdata,
    input  logic [KEEP_W-1:0]     rx_tkeep,
    input  logic                  rx_tvalid,
    input  logic                  rx_tlast,
    input  logic                  rx_tuser,
    output logic [CNT_W-1:0]      pkt_cnt,
    output logic [CNT_W-1:0]      err_cnt,
    output logic [CNT_W-1:0]      seq_err_cnt,
    output logic [BYTE_CNT_W-1:0] byte_cnt,
    output logic                  rx_done,
    output logic                  rx_data_fail,
    output logic                  rx_busy
);
    localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

    state_e            state_q, state_d;
    logic [1:0]        idx_q, beat_idx;
    logic [7:0]        seq8_q, seq8;
    logic              sop, accept, mism, keep_ok;
    logic              s1_vld_q, s1_sop_q, s1_last_q, s1_tuser_q;
    logic [31:0]       s1_seq_q, exp_seq_q;
    logic [6:0]        s1_pop_q;
    logic [LEN_W-1:0]  len_q, len_new;
    logic [LEN_W:0]    len_sum;
    logic              ferr_q, fseq_q, ferr_new, seq_bad, frame_err, proc, hit_done;
    logic [CNT_W-1:0]  pkt_q, err_q, seq_err_q, pkt_inc;
    logic              fail_q;

    assign sop      = state_q == WAIT_SOP;
    assign accept   = rx_tvalid && !rx_restart && (sop || state_q == IN_PKT);
    assign beat_idx = sop ? 2'd0 : idx_q;
    assign seq8     = sop ? rx_tdata[7:0] : seq8_q;

    cmac_chk_beat_cmp u_cmp (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_i   (rx_tdata),
        .keep_i   (rx_tkeep),
        .idx_i    (beat_idx),
        .seq8_i   (seq8),
        .first_i  (sop),
        .last_i   (rx_tlast),
        .mism_o   (mism),
        .keep_ok_o(keep_ok)
    );

    // Second stage: fold the registered beat into the frame verdict; restart discards it.
    assign proc      = s1_vld_q && !rx_restart && state_q != DONE;
    assign len_sum   = (s1_sop_q ? '0 : {1'b0, len_q}) + (LEN_W+1)'(s1_pop_q);
    assign len_new   = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];
    assign seq_bad   = s1_sop_q ? s1_seq_q != exp_seq_q : fseq_q;
    assign ferr_new  = (!s1_sop_q && ferr_q) || mism || !keep_ok;
    assign frame_err = ferr_new || seq_bad || s1_tuser_q || len_new < MIN_L || len_new > MAX_L;
    assign pkt_inc   = sat_inc(pkt_q);
    assign hit_done  = proc && s1_last_q && NUM_PKTS != 0 && pkt_inc == CNT_W'(NUM_PKTS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_SOP:     if (rx_tvalid && !rx_tlast) state_d = IN_PKT;
            IN_PKT, DROP: if (rx_tvalid && rx_tlast)  state_d = WAIT_SOP;
            default:      ;
        endcase
        if (hit_done) state_d = DONE;
        if (rx_restart) state_d = (state_q == IN_PKT || (rx_tvalid && !rx_tlast)) ? DROP : WAIT_SOP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            seq8_q     <= '0;
            s1_vld_q   <= 1'b0;
            s1_sop_q   <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_tuser_q <= 1'b0;
            s1_seq_q   <= '0;
            s1_pop_q   <= '0;
            len_q      <= '0;
            ferr_q     <= 1'b0;
            fseq_q     <= 1'b0;
            exp_seq_q  <= '0;
            pkt_q      <= '0;
            err_q      <= '0;
            seq_err_q  <= '0;
            fail_q     <= 1'b0;
        end else begin
            s1_vld_q <= accept;
            if (accept) begin
                idx_q      <= beat_idx + 2'd1;
                s1_sop_q   <= sop;
                s1_last_q  <= rx_tlast;
                s1_tuser_q <= rx_tuser;
                s1_seq_q   <= rx_tdata[31:0];
                s1_pop_q   <= 7'($countones(rx_tkeep));
                if (sop) seq8_q <= rx_tdata[7:0];
            end
            if (rx_restart) begin
                exp_seq_q <= '0;
                pkt_q     <= '0;
                err_q     <= '0;
                seq_err_q <= '0;
                fail_q    <= 1'b0;
            end else if (proc) begin
                len_q  <= len_new;
                ferr_q <= ferr_new;
                fseq_q <= seq_bad;
                if (s1_sop_q) exp_seq_q <= s1_seq_q + 32'd1;
                if (s1_last_q) begin
                    pkt_q <= pkt_inc;
                    if (frame_err) begin
                        err_q  <= sat_inc(err_q);
                        fail_q <= 1'b1;
                    end
                    if (seq_bad) seq_err_q <= sat_inc(seq_err_q);
                end
            end
        end
    end

`ifdef CMAC_RX_CHK_BYTE_CNT_EN
    logic [BYTE_CNT_W-1:0] byte_q;
    logic [BYTE_CNT_W:0]   byte_sum;

    assign byte_sum = {1'b0, byte_q} + (BYTE_CNT_W+1)'(s1_pop_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          byte_q <= '0;
        else if (rx_restart) byte_q <= '0;
        else if (proc)       byte_q <= byte_sum[BYTE_CNT_W] ? '1 : byte_sum[BYTE_CNT_W-1:0];
    end

    assign byte_cnt = byte_q;
`else
    assign byte_cnt = '0;
`endif

    assign pkt_cnt      = pkt_q;
    assign err_cnt      = err_q;
    assign seq_err_cnt  = seq_err_q;
    assign rx_data_fail = fail_q;
    assign rx_done      = state_q == DONE;
    assign rx_busy      = state_q inside {WAIT_SOP, IN_PKT, DROP};
endmodule

// File: tb/tb_cmac_rx_pkt_checker.sv
// tb_cmac_rx_pkt_checker: scoreboard bench with a frame-level reference model of the RX checker.
module tb_cmac_rx_pkt_checker;
    localparam int NP = 4;
`ifdef CMAC_RX_CHK_BYTE_CNT_EN
    localparam longint EXP_BC = 1629;
`else
    localparam longint EXP_BC = 0;
`endif

    logic         clk = 1'b0, rst_n = 1'b1;
    logic         rx_restart = 1'b0, rx_tvalid = 1'b0, rx_tlast = 1'b0, rx_tuser = 1'b0;
    logic [511:0] rx_tdata = '0;
    logic [63:0]  rx_tkeep = '0;
    logic [31:0]  pkt_cnt, err_cnt, seq_err_cnt;
    logic [47:0]  byte_cnt;
    logic         rx_done, rx_data_fail, rx_busy;

    cmac_rx_pkt_checker #(.NUM_PKTS(NP), .MIN_LEN(64), .MAX_LEN(9600)) dut (
        .clk(clk), .rst_n(rst_n), .rx_restart(rx_restart), .rx_tdata(rx_tdata),
        .rx_tkeep(rx_tkeep), .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast), .rx_tuser(rx_tuser),
        .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .seq_err_cnt(seq_err_cnt), .byte_cnt(byte_cnt),
        .rx_done(rx_done), .rx_data_fail(rx_data_fail), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint pkt, err, serr, bytes;
        logic   fail;
    } snap_t;

    snap_t       q[$];
    int          n_vec = 0, n_fail = 0;
    longint      m_pkt, m_err, m_serr, m_bytes;
    logic        m_fail;
    logic [31:0] m_exp;
    logic [31:0] mon_prev = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void m_reset();
        m_pkt = 0; m_err = 0; m_serr = 0; m_bytes = 0; m_fail = 1'b0; m_exp = '0;
    endfunction

    function automatic logic [63:0] mask(input int n);
        logic [63:0] m = '0;
        for (int i = 0; i < n; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic contig(input logic [63:0] k);
        for (int n = 1; n <= 64; n++) if (k == mask(n)) return 1'b1;
        return 1'b0;
    endfunction

    // Drives one frame and, if it should be counted, pushes the expected counter snapshot.
    task automatic send_frame(input int len, input logic [31:0] seq, input int cpos, input logic [7:0] cval,
                              input logic tuser, input logic kov_en, input logic [63:0] kov,
                              input int gap, input logic count, input int rs_beat);
        int          nb = (len + 63) / 64;
        int          plen = 0;
        logic        err = 1'b0, cnt = count, seqbad;
        logic [31:0] rseq = '0;
        logic [511:0] d;
        logic [63:0] k;
        for (int b = 0; b < nb; b++) begin
            for (int j = 0; j < 64; j++) begin
                int p = b * 64 + j;
                logic [7:0] v;
                v = p < 4 ? seq[8*p +: 8] : p < len ? 8'((p + int'(seq[7:0])) % 256) : 8'($urandom);
                if (p == cpos) v = cval;
                d[8*j +: 8] = v;
            end
            k = (b < nb - 1) ? '1 : kov_en ? kov : mask(len - b * 64);
            if (b == 0) rseq = d[31:0];
            plen += $countones(k);
            if (b < nb - 1 ? k != '1 : !contig(k)) err = 1'b1;
            for (int j = 0; j < 64; j++)
                if (k[j] && b * 64 + j >= 4 && d[8*j +: 8] != 8'((b * 64 + j + int'(rseq[7:0])) % 256)) err = 1'b1;
            @(negedge clk);
            rx_tvalid = 1'b1; rx_tdata = d; rx_tkeep = k;
            rx_tlast = (b == nb - 1); rx_tuser = (b == nb - 1) && tuser;
            rx_restart = (b == rs_beat);
            if (b == rs_beat) begin
                m_reset();
                cnt = 1'b0;
            end
        end
        if (cnt && m_pkt < NP) begin
            seqbad = rseq != m_exp;
            m_exp = rseq + 1;
            m_pkt++;
            if (err || tuser || plen < 64 || plen > 9600 || seqbad) begin
                m_err++;
                m_fail = 1'b1;
            end
            if (seqbad) m_serr++;
`ifdef CMAC_RX_CHK_BYTE_CNT_EN
            m_bytes += plen;
`endif
            q.push_back('{m_pkt, m_err, m_serr, m_bytes, m_fail});
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tuser = 1'b0; rx_restart = 1'b0;
        end
    endtask

    task automatic clean(input int len, input logic [31:0] seq, input int gap);
        send_frame(len, seq, -1, 8'h00, 1'b0, 1'b0, '0, gap, 1'b1, -1);
    endtask

    task automatic restart();
        @(negedge clk);
        rx_restart = 1'b1; rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tuser = 1'b0;
        m_reset();
        @(negedge clk);
        rx_restart = 1'b0;
        chk("busy_after_restart", rx_busy, 1);
        chk("pkt_after_restart", pkt_cnt, 0);
    endtask

    task automatic settle();
        int t = 0;
        @(negedge clk);
        rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tuser = 1'b0; rx_restart = 1'b0;
        while (q.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            n_vec++; n_fail++;
            $display("FAIL settle_timeout: %0d frames outstanding, expected 0", q.size());
            q.delete();
        end
        repeat (3) @(negedge clk);
        chk("pkt_cnt", pkt_cnt, m_pkt);
        chk("err_cnt", err_cnt, m_err);
        chk("seq_err_cnt", seq_err_cnt, m_serr);
        chk("byte_cnt", byte_cnt, m_bytes);
        chk("rx_data_fail", rx_data_fail, m_fail);
        chk("rx_done", rx_done, m_pkt == NP);
        chk("rx_busy", rx_busy, m_pkt != NP);
    endtask

    initial begin
        snap_t s;
        forever begin
            @(negedge clk);
            if (pkt_cnt != mon_prev) begin
                if (pkt_cnt == mon_prev + 1) begin
                    if (q.size() == 0) begin
                        n_vec++; n_fail++;
                        $display("FAIL unexpected_frame: pkt_cnt %0d, nothing expected", pkt_cnt);
                    end else begin
                        s = q.pop_front();
                        chk("mon_pkt", pkt_cnt, s.pkt);
                        chk("mon_err", err_cnt, s.err);
                        chk("mon_seq_err", seq_err_cnt, s.serr);
                        chk("mon_bytes", byte_cnt, s.bytes);
                        chk("mon_fail", rx_data_fail, s.fail);
                    end
                end
                mon_prev = pkt_cnt;
            end
        end
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] cur, sq;
        int          len, nf;
        m_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_pkt", pkt_cnt, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_seq", seq_err_cnt, 0);
        chk("rst_bytes", byte_cnt, 0);
        chk("rst_done", rx_done, 0);
        chk("rst_fail", rx_data_fail, 0);
        chk("rst_busy", rx_busy, 0);

        // four back-to-back clean frames reach DONE; a later frame is ignored
        restart();
        for (int i = 0; i < 4; i++) clean(128, i, 0);
        settle();
        chk("s1_done", rx_done, 1);
        chk("s1_err", err_cnt, 0);
        clean(128, 4, 2);
        settle();
        chk("s1_after_done", pkt_cnt, 4);

        restart();
        clean(100, 0, 0); clean(100, 1, 1); clean(100, 5, 0); clean(100, 6, 0);
        settle();
        chk("s2_seq_err", seq_err_cnt, 1);
        chk("s2_err", err_cnt, 1);

        restart();
        clean(128, 0, 0); clean(128, 1, 0);
        send_frame(128, 2, 70, 8'h00, 1'b0, 1'b0, '0, 0, 1'b1, -1);
        settle();
        chk("s3_corrupt_err", err_cnt, 1);

        restart();
        clean(128, 0, 0); clean(128, 1, 0);
        send_frame(128, 2, -1, 8'h00, 1'b1, 1'b0, '0, 0, 1'b1, -1);
        settle();
        chk("s3_tuser_err", err_cnt, 1);

        restart();
        clean(63, 0, 0); clean(64, 1, 0); clean(9600, 2, 0); clean(9601, 3, 0);
        settle();
        chk("s4_len_err", err_cnt, 2);

        restart();
        send_frame(100, 0, -1, 8'h00, 1'b0, 1'b1, 64'h0F0F, 1, 1'b1, -1);
        settle();
        chk("s5_keep_err", err_cnt, 1);

        restart();
        send_frame(256, 7, -1, 8'h00, 1'b0, 1'b0, '0, 1, 1'b1, 1);
        clean(128, 0, 1);
        settle();
        chk("s6_pkt", pkt_cnt, 1);
        chk("s6_err", err_cnt, 0);

        // restart one cycle after tlast must discard that completion
        restart();
        send_frame(128, 0, -1, 8'h00, 1'b0, 1'b0, '0, 0, 1'b0, -1);
        restart();
        clean(128, 0, 1);
        settle();
        chk("s7_pkt", pkt_cnt, 1);
        chk("s7_err", err_cnt, 0);

        restart();
        clean(64, 0, 0); clean(65, 1, 0); clean(1500, 2, 0);
        settle();
        chk("s8_byte_cnt", byte_cnt, EXP_BC);

        for (int r = 0; r < 25; r++) begin
            restart();
            nf = $urandom_range(1, 4);
            cur = 0;
            for (int f = 0; f < nf; f++) begin
                len = ($urandom % 8 == 0) ? $urandom_range(9500, 9700) : $urandom_range(1, 300);
                sq = ($urandom % 5 == 0) ? $urandom : cur;
                cur = sq + 1;
                send_frame(len, sq, ($urandom % 6 == 0) ? $urandom_range(0, len - 1) : -1, 8'($urandom),
                           $urandom % 8 == 0, $urandom % 10 == 0, {$urandom, $urandom},
                           $urandom_range(0, 2), 1'b1, -1);
            end
            settle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
